node_ni: RTL and testbench

Synthesizable, parametrised network interface that connects one processing element to its mesh router's local port. It turns local packet requests into a header flit plus DATA_FLITS body/tail flits on the router link, using the four-phase req/ack link handshake. It reassembles inbound flit streams into packets for the local element. A TX packet queue and RX backpressure provide buffering that a simple behavioural node does not have.

---
 rtl/node_ni.sv | 273 +++++++++++++++++++++++++++
 tb/tb_node_ni.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_ni.sv
// Mesh network interface: packet TX queue + four-phase link serializer,
// and a four-phase link receiver that reassembles flits into packets.
module node_ni #(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DATA_FLITS = 4,
  parameter int unsigned TX_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  input  logic [ID_W-1:0]                tx_dest,
  input  logic [DATA_FLITS*DATA_W-1:0]   tx_data,
  output logic                           tx_drop,
  output logic [DATA_W+1:0]              data_out,
  output logic                           req_out,
  input  logic                           ack_out,
  input  logic [DATA_W+1:0]              data_in,
  input  logic                           req_in,
  output logic                           ack_in,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  output logic [ID_W-1:0]                rx_src,
  output logic [DATA_W-2*ID_W-1:0]       rx_pnum,
  output logic [DATA_FLITS*DATA_W-1:0]   rx_data,
  output logic                           rx_err
);
  localparam int unsigned PNUM_W = DATA_W - 2*ID_W;
  localparam int unsigned PW     = DATA_FLITS*DATA_W;
  localparam int unsigned FW     = DATA_W + 2;
  localparam int unsigned AW     = $clog2(TX_DEPTH);
  localparam int unsigned CW     = $clog2(DATA_FLITS + 1);

  localparam logic [ID_W-1:0] MY_ID   = ID_W'(NODE_ID);
  localparam logic [CW-1:0]   TX_LAST = CW'(DATA_FLITS - 1);
  localparam logic [CW-1:0]   RX_LAST = CW'(DATA_FLITS);
  localparam logic [1:0]      FT_BODY = 2'b00;
  localparam logic [1:0]      FT_HDR  = 2'b01;
  localparam logic [1:0]      FT_TAIL = 2'b10;

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT, T_SEND} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_GAP, R_CAP} rx_state_e;

  // ---------------- TX queue ----------------
  logic [PNUM_W-1:0] q_pnum [TX_DEPTH];
  logic [ID_W-1:0]   q_dest [TX_DEPTH];
  logic [PW-1:0]     q_data [TX_DEPTH];

  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [PNUM_W-1:0] pnum_q, pnum_d;
  logic              drop_q, drop_d;
  logic              empty, full, accept, push, deq;

  assign wr_idx   = wr_q[AW-1:0];
  assign rd_idx   = rd_q[AW-1:0];
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
  assign tx_ready = !full;
  assign accept   = tx_valid && !full;
  assign push     = accept && (tx_dest != MY_ID);
  assign tx_drop  = drop_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    pnum_d = pnum_q;
    drop_d = accept && (tx_dest == MY_ID);
    if (push) begin
      wr_d   = wr_q + 1'b1;
      pnum_d = pnum_q + 1'b1;
    end
    if (deq) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pnum[wr_idx] <= pnum_q;
      q_dest[wr_idx] <= tx_dest;
      q_data[wr_idx] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      pnum_q <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      pnum_q <= pnum_d;
      drop_q <= drop_d;
    end
  end

  // ---------------- TX link FSM ----------------
  tx_state_e       tx_st_q, tx_st_d;
  logic            req_q, req_d;
  logic [FW-1:0]   dout_q, dout_d;
  logic [PW-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic            tx_last;

  assign tx_last  = (tcnt_q == TX_LAST);
  assign req_out  = req_q;
  assign data_out = dout_q;

  always_comb begin
    tx_st_d = tx_st_q;
    req_d   = req_q;
    dout_d  = dout_q;
    sh_d    = sh_q;
    hdr_d   = hdr_q;
    tcnt_d  = tcnt_q;
    deq     = 1'b0;
    case (tx_st_q)
      T_IDLE: if (!empty) begin
        deq     = 1'b1;
        sh_d    = q_data[rd_idx];
        hdr_d   = {q_pnum[rd_idx], MY_ID, q_dest[rd_idx]};
        req_d   = 1'b1;
        tx_st_d = T_REQ;
      end
      T_REQ: if (ack_out) begin
        req_d   = 1'b0;
        tx_st_d = T_WAIT;
      end
      T_WAIT: if (!ack_out) begin
        dout_d  = {FT_HDR, hdr_q};
        tcnt_d  = '0;
        tx_st_d = T_SEND;
      end
      T_SEND: begin
        // Payload shifts out MSB chunk first; the last chunk is typed as tail.
        dout_d = {(tx_last ? FT_TAIL : FT_BODY), sh_q[PW-1 -: DATA_W]};
        sh_d   = sh_q << DATA_W;
        tcnt_d = tcnt_q + CW'(1);
        if (tx_last) tx_st_d = T_IDLE;
      end
      default: tx_st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q <= T_IDLE;
      req_q   <= 1'b0;
      dout_q  <= '0;
      sh_q    <= '0;
      hdr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      tx_st_q <= tx_st_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      sh_q    <= sh_d;
      hdr_q   <= hdr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // ---------------- RX link FSM ----------------
  rx_state_e              rx_st_q, rx_st_d;
  logic                   ack_q, ack_d;
  logic [CW-1:0]          rcnt_q, rcnt_d;
  logic [DATA_W-ID_W-1:0] rhdr_q, rhdr_d;
  logic [PW-1:0]          rbuf_q, rbuf_d, rnext;
  logic                   racc_q, racc_d;
  logic                   rxv_q, rxv_d;
  logic [ID_W-1:0]        rsrc_q, rsrc_d;
  logic [PNUM_W-1:0]      rpnum_q, rpnum_d;
  logic [PW-1:0]          rdata_q, rdata_d;
  logic                   rerr_q, rerr_d;
  logic [1:0]             in_type, exp_type;
  logic [DATA_W-1:0]      in_field;
  logic                   in_bad;

  assign in_type  = data_in[FW-1 -: 2];
  assign in_field = data_in[DATA_W-1:0];
  assign rnext    = (rbuf_q << DATA_W) | PW'(in_field);
  assign exp_type = (rcnt_q == '0)    ? FT_HDR :
                    (rcnt_q == RX_LAST) ? FT_TAIL : FT_BODY;
  assign in_bad   = (in_type != exp_type);

  assign ack_in   = ack_q;
  assign rx_valid = rxv_q;
  assign rx_src   = rsrc_q;
  assign rx_pnum  = rpnum_q;
  assign rx_data  = rdata_q;
  assign rx_err   = rerr_q;

  always_comb begin
    rx_st_d = rx_st_q;
    ack_d   = ack_q;
    rcnt_d  = rcnt_q;
    rhdr_d  = rhdr_q;
    rbuf_d  = rbuf_q;
    racc_d  = racc_q;
    rxv_d   = rxv_q && !rx_ready;
    rsrc_d  = rsrc_q;
    rpnum_d = rpnum_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (rx_st_q)
      // A pending delivery holds off the next link request.
      R_IDLE: if (req_in && !rxv_q) begin
        ack_d   = 1'b1;
        rx_st_d = R_ACK;
      end
      R_ACK: if (!req_in) begin
        ack_d   = 1'b0;
        rx_st_d = R_GAP;
      end
      R_GAP: begin
        rcnt_d  = '0;
        rx_st_d = R_CAP;
      end
      R_CAP: begin
        rcnt_d = rcnt_q + CW'(1);
        if (rcnt_q == '0) begin
          rhdr_d = in_field[DATA_W-1:ID_W];
          racc_d = in_bad;
        end else begin
          rbuf_d = rnext;
          racc_d = racc_q | in_bad;
          if (rcnt_q == RX_LAST) begin
            rxv_d   = 1'b1;
            rsrc_d  = rhdr_q[ID_W-1:0];
            rpnum_d = rhdr_q[DATA_W-ID_W-1:ID_W];
            rdata_d = rnext;
            rerr_d  = racc_q | in_bad;
            rx_st_d = R_IDLE;
          end
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q <= R_IDLE;
      ack_q   <= 1'b0;
      rcnt_q  <= '0;
      rhdr_q  <= '0;
      rbuf_q  <= '0;
      racc_q  <= 1'b0;
      rxv_q   <= 1'b0;
      rsrc_q  <= '0;
      rpnum_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      ack_q   <= ack_d;
      rcnt_q  <= rcnt_d;
      rhdr_q  <= rhdr_d;
      rbuf_q  <= rbuf_d;
      racc_q  <= racc_d;
      rxv_q   <= rxv_d;
      rsrc_q  <= rsrc_d;
      rpnum_q <= rpnum_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_node_ni.sv
// Directed bench: two node_ni instances (IDs 0 and 5) linked back-to-back,
// plus a bench-driven flit source into node 0's receiver.
module tb_node_ni;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        tx_valid0, tx_ready0, tx_drop0, req_out0, ack_out0, req_in0, ack_in0;
  logic        rx_valid0, rx_ready0, rx_err0;
  logic [3:0]  tx_dest0, rx_src0;
  logic [63:0] tx_data0, rx_data0;
  logic [17:0] data_out0, data_in0;
  logic [7:0]  rx_pnum0;

  logic        tx_valid5, tx_ready5, tx_drop5, req_out5, ack_out5, req_in5, ack_in5;
  logic        rx_valid5, rx_ready5, rx_err5;
  logic [3:0]  tx_dest5, rx_src5;
  logic [63:0] tx_data5, rx_data5;
  logic [17:0] data_out5, data_in5;
  logic [7:0]  rx_pnum5;

  logic        hold_ack, bfm_en, bfm_req;
  logic [17:0] bfm_data;

  assign ack_out0 = hold_ack ? 1'b0 : ack_in5;
  assign req_in0  = bfm_en ? bfm_req  : req_out5;
  assign data_in0 = bfm_en ? bfm_data : data_out5;
  assign ack_out5 = ack_in0;
  assign req_in5  = req_out0;
  assign data_in5 = data_out0;

  node_ni #(.NODE_ID(0), .ID_W(4), .DATA_W(16), .DATA_FLITS(4), .TX_DEPTH(4)) u0 (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_dest(tx_dest0), .tx_data(tx_data0),
    .tx_drop(tx_drop0), .data_out(data_out0), .req_out(req_out0), .ack_out(ack_out0),
    .data_in(data_in0), .req_in(req_in0), .ack_in(ack_in0),
    .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_src(rx_src0), .rx_pnum(rx_pnum0),
    .rx_data(rx_data0), .rx_err(rx_err0));

  node_ni #(.NODE_ID(5), .ID_W(4), .DATA_W(16), .DATA_FLITS(4), .TX_DEPTH(4)) u5 (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid5), .tx_ready(tx_ready5), .tx_dest(tx_dest5), .tx_data(tx_data5),
    .tx_drop(tx_drop5), .data_out(data_out5), .req_out(req_out5), .ack_out(ack_out5),
    .data_in(data_in5), .req_in(req_in5), .ack_in(ack_in5),
    .rx_valid(rx_valid5), .rx_ready(rx_ready5), .rx_src(rx_src5), .rx_pnum(rx_pnum5),
    .rx_data(rx_data5), .rx_err(rx_err5));

  typedef struct {
    logic [3:0]  src;
    logic [7:0]  pnum;
    logic [63:0] data;
    logic        err;
  } pkt_t;
  pkt_t sb5[$];

  always @(negedge clk) begin
    pkt_t p;
    if (!rst && rx_valid5 && rx_ready5) begin
      p.src  = rx_src5;
      p.pnum = rx_pnum5;
      p.data = rx_data5;
      p.err  = rx_err5;
      sb5.push_back(p);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] dest, input logic [63:0] data);
    logic acc;
    acc = 1'b0;
    tx_valid0 = 1'b1;
    tx_dest0  = dest;
    tx_data0  = data;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = tx_ready0;
      tick();
    end
    tx_valid0 = 1'b0;
    chk("enq_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_sb(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && sb5.size() < n; i++) tick();
    chk(tag, 64'(sb5.size()), 64'(n));
  endtask

  task automatic wait_hdr(input string tag);
    for (int i = 0; i < 60 && data_out0[17:16] !== 2'b01; i++) tick();
    chk(tag, 64'(data_out0[17:16]), 64'd1);
  endtask

  task automatic bfm_send(input logic [1:0] ttype, input logic [7:0] pn,
                          input logic [3:0] src, input logic [63:0] pay);
    bfm_req = 1'b1;
    for (int i = 0; i < 20 && ack_in0 !== 1'b1; i++) tick();
    chk("bfm_ack_hi", 64'(ack_in0), 64'd1);
    bfm_req = 1'b0;
    for (int i = 0; i < 20 && ack_in0 !== 1'b0; i++) tick();
    chk("bfm_ack_lo", 64'(ack_in0), 64'd0);
    tick();
    bfm_data = {2'b01, pn, src, 4'd0};
    for (int k = 0; k < 4; k++) begin
      tick();
      bfm_data = {((k == 3) ? ttype : 2'b00), pay[63-16*k -: 16]};
    end
    tick();
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [15:0] w;
    w = 16'hA000 + 16'(i);
    return {w, w, w, w};
  endfunction

  logic [17:0] exp_fl [5] = '{18'h10005, 18'h00123, 18'h04567, 18'h089AB, 18'h2CDEF};
  logic        saw;
  int          bad;

  initial begin
    rst = 1'b1;
    tx_valid0 = 1'b0; tx_dest0 = '0; tx_data0 = '0;
    tx_valid5 = 1'b0; tx_dest5 = '0; tx_data5 = '0;
    rx_ready0 = 1'b1; rx_ready5 = 1'b1;
    hold_ack = 1'b0; bfm_en = 1'b0; bfm_req = 1'b0; bfm_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_req_out",  64'(req_out0),  64'd0);
    chk("rst_ack_in",   64'(ack_in0),   64'd0);
    chk("rst_data_out", 64'(data_out0), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready0), 64'd1);
    chk("rst_tx_drop",  64'(tx_drop0),  64'd0);
    chk("rst_rx_valid", 64'(rx_valid0), 64'd0);
    chk("rst_rx_err",   64'(rx_err0),   64'd0);
    chk("rst_rx_src",   64'(rx_src0),   64'd0);
    chk("rst_rx_pnum",  64'(rx_pnum0),  64'd0);
    chk("rst_rx_data",  rx_data0,       64'd0);
    chk("rst_tx_ready5", 64'(tx_ready5), 64'd1);
    chk("rst_tx_drop5",  64'(tx_drop5),  64'd0);

    // self-addressed packet is discarded
    enq(4'd0, 64'hDEAD_BEEF_0000_1111);
    chk("drop_pulse", 64'(tx_drop0), 64'd1);
    tick();
    chk("drop_once", 64'(tx_drop0), 64'd0);
    saw = 1'b0;
    repeat (6) begin tick(); saw |= req_out0; end
    chk("drop_no_req", 64'(saw), 64'd0);

    // link transfer to node 5, flit by flit
    sb5.delete();
    enq(4'd5, 64'h0123_4567_89AB_CDEF);
    chk("req_lat_e0", 64'(req_out0), 64'd0);
    tick();
    chk("req_lat_e1", 64'(req_out0), 64'd1);
    wait_hdr("link_hdr_seen");
    chk("flit0", 64'(data_out0), 64'(exp_fl[0]));
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("flit%0d", k), 64'(data_out0), 64'(exp_fl[k]));
    end
    wait_sb(1, 40, "link_deliver");
    if (sb5.size() >= 1) begin
      chk("link_src",  64'(sb5[0].src),  64'd0);
      chk("link_pnum", 64'(sb5[0].pnum), 64'd0);
      chk("link_data", sb5[0].data,      64'h0123_4567_89AB_CDEF);
      chk("link_err",  64'(sb5[0].err),  64'd0);
    end
    repeat (3) tick();
    chk("dout_hold", 64'(data_out0), 64'h2CDEF);

    // receiver backpressure
    sb5.delete();
    rx_ready5 = 1'b0;
    enq(4'd5, pat(100));
    for (int i = 0; i < 60 && rx_valid5 !== 1'b1; i++) tick();
    chk("bp_first_valid", 64'(rx_valid5), 64'd1);
    enq(4'd5, pat(101));
    repeat (30) tick();
    chk("bp_ack_held",    64'(ack_in5),  64'd0);
    chk("bp_req_pending", 64'(req_out0), 64'd1);
    rx_ready5 = 1'b1;
    tick();
    chk("bp_valid_clr", 64'(rx_valid5), 64'd0);
    chk("bp_ack_e0",    64'(ack_in5),   64'd0);
    tick();
    chk("bp_ack_e1",    64'(ack_in5),   64'd1);
    wait_sb(2, 60, "bp_deliver");
    if (sb5.size() >= 2) begin
      chk("bp_pnum_a", 64'(sb5[0].pnum), 64'd1);
      chk("bp_data_a", sb5[0].data,      pat(100));
      chk("bp_pnum_b", 64'(sb5[1].pnum), 64'd2);
      chk("bp_data_b", sb5[1].data,      pat(101));
    end

    // link stalled: one packet in flight, queue fills behind it
    sb5.delete();
    hold_ack = 1'b1;
    for (int i = 0; i < 5; i++) enq(4'd5, pat(i));
    chk("hold_full", 64'(tx_ready0), 64'd0);
    tx_valid0 = 1'b1; tx_dest0 = 4'd5; tx_data0 = pat(5);
    repeat (10) tick();
    chk("hold_still_full", 64'(tx_ready0), 64'd0);
    chk("hold_req",        64'(req_out0),  64'd1);
    hold_ack = 1'b0;
    enq(4'd5, pat(5));
    wait_sb(6, 200, "hold_deliver");
    for (int i = 0; i < 6; i++) begin
      if (i < sb5.size()) begin
        chk($sformatf("hold_pnum%0d", i), 64'(sb5[i].pnum), 64'(3 + i));
        chk($sformatf("hold_data%0d", i), sb5[i].data,      pat(i));
      end
    end

    // bench-driven flits into node 0: clean packet, then bad tail type
    bfm_en = 1'b1;
    bfm_send(2'b10, 8'h42, 4'd5, 64'h1111_2222_3333_4444);
    chk("bfm_good_valid", 64'(rx_valid0), 64'd1);
    chk("bfm_good_err",   64'(rx_err0),   64'd0);
    chk("bfm_good_src",   64'(rx_src0),   64'd5);
    chk("bfm_good_pnum",  64'(rx_pnum0),  64'h42);
    chk("bfm_good_data",  rx_data0,       64'h1111_2222_3333_4444);
    tick();
    bfm_send(2'b00, 8'h43, 4'd5, 64'h5555_6666_7777_8888);
    chk("bfm_bad_valid", 64'(rx_valid0), 64'd1);
    chk("bfm_bad_err",   64'(rx_err0),   64'd1);
    chk("bfm_bad_pnum",  64'(rx_pnum0),  64'h43);
    chk("bfm_bad_data",  rx_data0,       64'h5555_6666_7777_8888);
    bfm_en = 1'b0;
    tick();

    // reset in the middle of a packet, with another packet queued
    sb5.delete();
    enq(4'd5, pat(10));
    enq(4'd5, pat(11));
    wait_hdr("rst_hdr_seen");
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_req",   64'(req_out0),  64'd0);
    chk("rst_mid_dout",  64'(data_out0), 64'd0);
    chk("rst_mid_ready", 64'(tx_ready0), 64'd1);
    rst = 1'b0;
    saw = 1'b0;
    repeat (30) begin tick(); saw |= req_out0; end
    chk("rst_queue_empty", 64'(saw), 64'd0);
    chk("rst_no_deliver",  64'(sb5.size()), 64'd0);

    // packet number wraps after 256 packets
    sb5.delete();
    for (int i = 0; i < 257; i++) enq(4'd5, 64'(i));
    wait_sb(257, 4000, "wrap_count");
    bad = 0;
    for (int i = 0; i < sb5.size(); i++)
      if (sb5[i].pnum !== 8'(i) || sb5[i].data !== 64'(i)) bad++;
    chk("wrap_order", 64'(bad), 64'd0);
    if (sb5.size() >= 257) begin
      chk("wrap_256th_pnum", 64'(sb5[255].pnum), 64'hFF);
      chk("wrap_257th_pnum", 64'(sb5[256].pnum), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
